uart_tx_stream: RTL and testbench

Serial transmitter stage that sits directly downstream of fifo_sync. It pops one word per frame over the FIFO's valid/ready read interface (data_o/valid_o/ready_i). It then shifts that word out as an asynchronous serial frame: start bit, LSB-first data, optional parity, and one or two stop bits. Bit timing comes from an internal baud counter clocked by the system clock.

---
 rtl/uart_tx_stream.sv | 152 +++++++++++++++
 tb/tb_uart_tx_stream.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_stream.sv
// UART transmitter fed from a valid/ready word stream.
// Frames: start, LSB-first data, optional parity, 1-2 stop bits.
module uart_tx_stream #(
   parameter int size_p         = 8,
   parameter int clks_per_bit_p = 16,
   parameter int parity_p       = 0,
   parameter int stop_bits_p    = 1,
   parameter int cw_p           = $clog2(clks_per_bit_p)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [size_p-1:0] data_i,
   input  logic              valid_i,
   output logic              ready_o,
   output logic              tx_o,
   output logic              busy_o
);

   if (clks_per_bit_p < 2 || parity_p < 0 || parity_p > 2 ||
       stop_bits_p < 1 || stop_bits_p > 2) begin : g_bad_param
      $error("uart_tx_stream: illegal parameter value");
   end

   localparam int iw_lp = (size_p > 2) ? $clog2(size_p) : 1;
   localparam logic [cw_p-1:0]  BAUD_LAST = cw_p'(clks_per_bit_p - 1);
   localparam logic [cw_p-1:0]  BAUD_ONE  = cw_p'(1);
   localparam logic [iw_lp-1:0] DATA_LAST = iw_lp'(size_p - 1);
   localparam logic [iw_lp-1:0] STOP_LAST = iw_lp'(stop_bits_p - 1);
   localparam logic [iw_lp-1:0] IDX_ONE   = iw_lp'(1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_e;

   state_e             state_q, state_d;
   logic [cw_p-1:0]    cnt_q, cnt_d;
   logic [iw_lp-1:0]   idx_q, idx_d;
   logic [size_p-1:0]  data_q, data_d;
   logic               tx_q, tx_d;
   logic               busy_q, busy_d;
   logic               bit_end;
   logic               accept;

   assign bit_end = (cnt_q == BAUD_LAST);
   assign ready_o = !rst && (state_q == IDLE ||
                    (state_q == STOP && idx_q == STOP_LAST && bit_end));
   assign accept  = valid_i && ready_o;
   assign tx_o    = tx_q;
   assign busy_o  = busy_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      data_d  = data_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = START;
               cnt_d   = '0;
               idx_d   = '0;
               data_d  = data_i;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               cnt_d   = '0;
               idx_d   = '0;
            end else begin
               cnt_d = cnt_q + BAUD_ONE;
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               if (idx_q == DATA_LAST) begin
                  idx_d   = '0;
                  state_d = (parity_p != 0) ? PARITY : STOP;
               end else begin
                  idx_d = idx_q + IDX_ONE;
               end
            end else begin
               cnt_d = cnt_q + BAUD_ONE;
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_d = STOP;
               cnt_d   = '0;
               idx_d   = '0;
            end else begin
               cnt_d = cnt_q + BAUD_ONE;
            end
         end
         STOP: begin
            if (bit_end) begin
               cnt_d = '0;
               if (idx_q == STOP_LAST) begin
                  idx_d = '0;
                  if (accept) begin
                     state_d = START;
                     data_d  = data_i;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  idx_d = idx_q + IDX_ONE;
               end
            end else begin
               cnt_d = cnt_q + BAUD_ONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Line level is registered from the next state so tx_o leads no logic.
   always_comb begin
      tx_d   = 1'b1;
      busy_d = (state_d != IDLE);
      unique case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = data_d[idx_d];
         PARITY:  tx_d = (parity_p == 2) ? ~^data_d : ^data_d;
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed bench for uart_tx_stream: default, even/odd parity
// and two-stop-bit instances sharing clock, reset and data.
module tb_uart_tx_stream;

   logic       clk;
   logic       rst;
   logic [7:0] din;
   logic [3:0] v;
   logic [3:0] rdy;
   logic [3:0] tx;
   logic [3:0] busy;
   int         n_vec;
   int         n_err;
   int         acc;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   uart_tx_stream u_dflt (
      .clk(clk), .rst(rst), .data_i(din), .valid_i(v[0]),
      .ready_o(rdy[0]), .tx_o(tx[0]), .busy_o(busy[0]));

   uart_tx_stream #(.parity_p(1)) u_even (
      .clk(clk), .rst(rst), .data_i(din), .valid_i(v[1]),
      .ready_o(rdy[1]), .tx_o(tx[1]), .busy_o(busy[1]));

   uart_tx_stream #(.parity_p(2)) u_odd (
      .clk(clk), .rst(rst), .data_i(din), .valid_i(v[2]),
      .ready_o(rdy[2]), .tx_o(tx[2]), .busy_o(busy[2]));

   uart_tx_stream #(.stop_bits_p(2)) u_stop2 (
      .clk(clk), .rst(rst), .data_i(din), .valid_i(v[3]),
      .ready_o(rdy[3]), .tx_o(tx[3]), .busy_o(busy[3]));

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   // bits[i] is the i-th bit on the line; each lasts 16 cycles.
   task automatic send(input int s, input logic [7:0] d,
                       input logic [11:0] bits, input int nb,
                       input bit poke);
      int f;
      f = nb * 16;
      @(posedge clk); #1;
      chk($sformatf("rdy_pre%0d", s), rdy[s], 1'b1);
      v[s] = 1'b1;
      din  = d;
      @(posedge clk); #1;
      v[s] = 1'b0;
      din  = ~d;
      for (int k = 1; k <= f; k++) begin
         @(negedge clk);
         chk($sformatf("tx%0d_c%0d", s, k), tx[s], bits[(k-1)/16]);
         chk($sformatf("rdy%0d_c%0d", s, k), rdy[s], k == f);
         chk($sformatf("busy%0d_c%0d", s, k), busy[s], 1'b1);
         if (poke && k == 40) begin
            v[s] = 1'b1;
            din  = 8'h00;
         end
         if (poke && k == 60) v[s] = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("busy%0d_end", s), busy[s], 1'b0);
      chk($sformatf("tx%0d_end", s), tx[s], 1'b1);
   endtask

   initial begin
      logic [19:0] b2b;
      n_vec = 0;
      n_err = 0;
      rst   = 1'b1;
      v     = '0;
      din   = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rdy_in_rst", rdy[0], 1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_tx", tx[0], 1'b1);
      chk("rst_busy", busy[0], 1'b0);
      chk("rst_rdy", rdy[0], 1'b1);

      send(0, 8'hA5, {2'b00, 1'b1, 8'hA5, 1'b0}, 10, 1'b0);

      // back-to-back frames with valid held high
      b2b = {1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0};
      @(posedge clk); #1;
      v[0] = 1'b1;
      din  = 8'h00;
      @(posedge clk); #1;
      din  = 8'hFF;
      acc  = 1;
      for (int k = 1; k <= 320; k++) begin
         @(negedge clk);
         chk($sformatf("b2b_tx_c%0d", k), tx[0], b2b[(k-1)/16]);
         chk($sformatf("b2b_busy_c%0d", k), busy[0], 1'b1);
         chk($sformatf("b2b_rdy_c%0d", k), rdy[0], k == 160 || k == 320);
         if (k < 320 && v[0] && rdy[0]) acc++;
         if (k == 320) v[0] = 1'b0;
      end
      chk("b2b_accepts", acc, 2);
      @(negedge clk);
      chk("b2b_idle", busy[0], 1'b0);

      send(1, 8'h07, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 1'b0);
      send(2, 8'h07, {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 1'b0);
      send(3, 8'h3C, {1'b0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11, 1'b0);

      // reset during data bit 3
      @(posedge clk); #1;
      v[0] = 1'b1;
      din  = 8'h00;
      @(posedge clk); #1;
      v[0] = 1'b0;
      repeat (70) @(negedge clk);
      chk("mid_tx_bit3", tx[0], 1'b0);
      rst = 1'b1;
      #1;
      chk("mid_rdy_rst", rdy[1], 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_tx", tx[0], 1'b1);
      chk("abort_busy", busy[0], 1'b0);
      chk("abort_rdy", rdy[0], 1'b1);
      send(0, 8'h5A, {2'b00, 1'b1, 8'h5A, 1'b0}, 10, 1'b0);

      // valid while busy must not be consumed
      send(0, 8'h81, {2'b00, 1'b1, 8'h81, 1'b0}, 10, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
